// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the date/time edit controller: FSM states, field codes,
// field ranges and calendar helpers.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelYear,
    StSelMonth,
    StSelDay,
    StSelHour,
    StSelMin,
    StSelSec,
    StCommit
  } state_e;

  // Field order matches bin_time: year in the top byte, second in the bottom byte.
  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } time_t;

  localparam int unsigned SwMode   = 0;
  localparam int unsigned SwUp     = 1;
  localparam int unsigned SwDown   = 2;
  localparam int unsigned SwCancel = 3;

  localparam logic [2:0] FldYear  = 3'd0;
  localparam logic [2:0] FldMonth = 3'd1;
  localparam logic [2:0] FldDay   = 3'd2;
  localparam logic [2:0] FldHour  = 3'd3;
  localparam logic [2:0] FldMin   = 3'd4;
  localparam logic [2:0] FldSec   = 3'd5;

  localparam logic [7:0] YearMin   = 8'd0;
  localparam logic [7:0] YearMax   = 8'd99;
  localparam logic [7:0] MonthMin  = 8'd1;
  localparam logic [7:0] MonthMax  = 8'd12;
  localparam logic [7:0] DayMin    = 8'd1;
  localparam logic [7:0] HourMin   = 8'd0;
  localparam logic [7:0] HourMax   = 8'd23;
  localparam logic [7:0] MinSecMin = 8'd0;
  localparam logic [7:0] MinSecMax = 8'd59;

  localparam time_t ResetTime = time_t'({8'd0, 8'd1, 8'd1, 24'd0});

  // Years are 2000..2099, so year%4==0 is exactly the leap rule.
  function automatic logic [7:0] days_in_month(input logic [7:0] year, input logic [7:0] month);
    logic [7:0] d;
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
      8'd2:                    d = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
      default:                 d = 8'd31;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] step_field(input logic [7:0] val, input logic [7:0] min,
                                            input logic [7:0] max, input logic up);
    logic [7:0] r;
    if (up) begin
      r = (val >= max) ? min : val + 8'd1;
    end else begin
      r = (val <= min) ? max : val - 8'd1;
    end
    return r;
  endfunction

  function automatic logic [2:0] field_of(input state_e s);
    logic [2:0] f;
    case (s)
      StSelMonth: f = FldMonth;
      StSelDay:   f = FldDay;
      StSelHour:  f = FldHour;
      StSelMin:   f = FldMin;
      StSelSec:   f = FldSec;
      default:    f = FldYear;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Switch inputs, live date/time from the clock core, and the load/edit outputs.
interface time_set_ctrl_if;

  logic [3:0]  sw_in;
  logic [7:0]  year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic        set_time;
  logic [47:0] bin_time;
  logic        edit_active;
  logic [2:0]  edit_field;
  logic        blink;

  modport master (
    output sw_in, year, month, day, hour, minute, second,
    input  set_time, bin_time, edit_active, edit_field, blink
  );

  modport slave (
    input  sw_in, year, month, day, hour, minute, second,
    output set_time, bin_time, edit_active, edit_field, blink
  );

endinterface

// File: rtl/time_set_ctrl_sw_debounce.sv
// One push switch: 2-FF synchroniser, stable-count debounce, registered press pulse.
module sw_debounce #(
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, rise_q;
  logic [31:0] cnt_q;
  logic        hit;

  // The level flips on the DebounceCycles-th consecutive cycle that disagrees with it.
  assign hit = (sync2_q != level_q) && (cnt_q == 32'(DebounceCycles - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= hit & sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (hit) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Push-switch date/time editor: edits a shadow copy field by field and loads it into
// the clock core with a one-cycle set_time strobe on commit.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input logic           clk,
  input logic           rst,
  time_set_ctrl_if.slave bus
);

  import time_set_ctrl_pkg::*;

  state_e      state_q, state_d;
  time_t       shadow_q, shadow_step, bin_q, live;
  logic [3:0]  lvl, rise;
  logic [31:0] rep_cnt_q, rep_limit, to_cnt_q, blink_cnt_q;
  logic        rep_first_q, blink_q;
  logic        editing, cancel_ev, mode_ev, up_only, dn_only, held, rep_fire;
  logic        step_en, step_up, step_dn, any_press, timeout_hit;
  logic [7:0]  dmax;
  logic        unused_lvl;

  for (genvar i = 0; i < 4; i++) begin : g_sw
    sw_debounce #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (bus.sw_in[i]),
      .level_o(lvl[i]),
      .rise_o (rise[i])
    );
  end

  assign unused_lvl = ^{lvl[SwMode], lvl[SwCancel]};

  assign live = {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second};

  assign editing = (state_q != StIdle) && (state_q != StCommit);

  // Key priority: cancel > mode > up/down; up+down together never steps.
  assign cancel_ev = rise[SwCancel];
  assign mode_ev   = rise[SwMode] & ~cancel_ev;
  assign up_only   = lvl[SwUp] & ~lvl[SwDown];
  assign dn_only   = lvl[SwDown] & ~lvl[SwUp];
  assign held      = editing && (up_only || dn_only);
  assign rep_limit = rep_first_q ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);
  assign rep_fire  = held && !(rise[SwUp] || rise[SwDown]) && (rep_cnt_q == rep_limit);
  assign step_en   = editing && !cancel_ev && !rise[SwMode];
  assign step_up   = step_en && up_only && (rise[SwUp] || rep_fire);
  assign step_dn   = step_en && dn_only && (rise[SwDown] || rep_fire);
  assign any_press = (|rise) || step_up || step_dn;
  assign timeout_hit = editing && !any_press && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mode_ev) state_d = StSelYear;
      end
      StCommit: state_d = StIdle;
      default: begin
        if (cancel_ev || timeout_hit) begin
          state_d = StIdle;
        end else if (mode_ev) begin
          state_d = state_e'(state_q + 3'd1);
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    bus.edit_active = editing;
    bus.edit_field  = field_of(state_q);
    bus.set_time    = (state_q == StCommit);
    bus.bin_time    = bin_q;
    bus.blink       = blink_q;
  end

  // One step on the selected field, then clamp day if month/year shrank the month.
  always_comb begin
    shadow_step = shadow_q;
    case (state_q)
      StSelYear:  shadow_step.year   = step_field(shadow_q.year, YearMin, YearMax, step_up);
      StSelMonth: shadow_step.month  = step_field(shadow_q.month, MonthMin, MonthMax, step_up);
      StSelDay:   shadow_step.day    = step_field(shadow_q.day, DayMin,
                                         days_in_month(shadow_q.year, shadow_q.month), step_up);
      StSelHour:  shadow_step.hour   = step_field(shadow_q.hour, HourMin, HourMax, step_up);
      StSelMin:   shadow_step.minute = step_field(shadow_q.minute, MinSecMin, MinSecMax, step_up);
      StSelSec:   shadow_step.second = step_field(shadow_q.second, MinSecMin, MinSecMax, step_up);
      default: ;
    endcase
    dmax = days_in_month(shadow_step.year, shadow_step.month);
    if (shadow_step.day > dmax) shadow_step.day = dmax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= ResetTime;
      bin_q    <= ResetTime;
    end else begin
      if (state_q == StIdle && state_d == StSelYear) begin
        shadow_q <= live;
      end else if (step_up || step_dn) begin
        shadow_q <= shadow_step;
      end
      if (state_d == StCommit && state_q != StCommit) begin
        bin_q <= shadow_q;
      end
    end
  end

  // Auto-repeat: first repeat after REPEAT_DELAY, then every REPEAT_RATE while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (!held || rise[SwUp] || rise[SwDown]) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (!editing || any_press) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (!editing) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: key-press vector table plus timing sequences.
module tb_time_set_ctrl;

  import time_set_ctrl_pkg::*;

  localparam logic [3:0] KMode = 4'b0001;
  localparam logic [3:0] KUp   = 4'b0010;
  localparam logic [3:0] KDn   = 4'b0100;
  localparam logic [3:0] KCan  = 4'b1000;

  typedef struct {
    time_t      live;
    logic [3:0] keys;
    logic       act;
    logic [2:0] fld;
    logic       chk_sh;
    time_t      sh;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   set_cnt = 0;
  vec_t tbl[$];

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5),
    .TIMEOUT_CYCLES (200),
    .BLINK_CYCLES   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.set_time === 1'b1) set_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic time_t tm(input int y, input int mo, input int d, input int h,
                               input int mi, input int s);
    return time_t'({8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)});
  endfunction

  function automatic vec_t v(input time_t live, input logic [3:0] keys, input logic act,
                             input logic [2:0] fld, input logic chk_sh, input time_t sh);
    vec_t r;
    r.live = live; r.keys = keys; r.act = act; r.fld = fld; r.chk_sh = chk_sh; r.sh = sh;
    return r;
  endfunction

  task automatic set_live(input time_t t);
    bus.year = t.year; bus.month = t.month; bus.day = t.day;
    bus.hour = t.hour; bus.minute = t.minute; bus.second = t.second;
  endtask

  task automatic press(input logic [3:0] keys, input int hold);
    bus.sw_in = keys;
    repeat (hold) tick();
    bus.sw_in = 4'd0;
    repeat (8) tick();
  endtask

  task automatic commit_seq(input time_t exp);
    bus.sw_in = KMode;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 6) chk("commit early", 64'(bus.set_time), 64'(1'b0));
      if (c == 7) begin
        chk("commit strobe", 64'(bus.set_time), 64'(1'b1));
        chk("commit bin_time", 64'(bus.bin_time), 64'(exp));
        chk("commit edit_active", 64'(bus.edit_active), 64'(1'b0));
      end
      if (c == 8) begin
        chk("commit strobe end", 64'(bus.set_time), 64'(1'b0));
        chk("commit bin hold", 64'(bus.bin_time), 64'(exp));
      end
    end
    bus.sw_in = 4'd0;
    repeat (8) tick();
    chk("commit count", 64'(set_cnt), 64'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " set_time"}, 64'(bus.set_time), 64'(1'b0));
    chk({tag, " bin_time"}, 64'(bus.bin_time), 64'(48'h00_01_01_00_00_00));
    chk({tag, " edit_active"}, 64'(bus.edit_active), 64'(1'b0));
    chk({tag, " edit_field"}, 64'(bus.edit_field), 64'(3'd0));
    chk({tag, " blink"}, 64'(bus.blink), 64'(1'b0));
  endtask

  initial begin
    time_t a, b, c, t;
    int    mexp;
    a = tm(24, 3, 31, 13, 45, 10);
    b = tm(24, 2, 29, 13, 45, 10);
    c = tm(99, 12, 31, 23, 59, 59);

    // Session A: month/day steps with clamp, mode beats up, commit follows index 11.
    tbl.push_back(v(a, KMode, 1, 0, 1, a));
    tbl.push_back(v(a, KMode, 1, 1, 1, a));
    tbl.push_back(v(a, KDn, 1, 1, 1, tm(24, 2, 29, 13, 45, 10)));
    tbl.push_back(v(a, KMode, 1, 2, 1, tm(24, 2, 29, 13, 45, 10)));
    tbl.push_back(v(a, KDn, 1, 2, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(a, KMode, 1, 3, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(a, KMode | KUp, 1, 4, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(a, KUp, 1, 4, 1, tm(24, 2, 28, 13, 46, 10)));
    tbl.push_back(v(a, KDn, 1, 4, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(a, KMode, 1, 5, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(a, KDn, 1, 5, 1, tm(24, 2, 28, 13, 45, 9)));
    tbl.push_back(v(a, KUp, 1, 5, 1, tm(24, 2, 28, 13, 45, 10)));
    // Session B: leap-year clamp on year step, cancel at SEL_HOUR.
    tbl.push_back(v(b, KMode, 1, 0, 1, b));
    tbl.push_back(v(b, KUp, 1, 0, 1, tm(25, 2, 28, 13, 45, 10)));
    tbl.push_back(v(b, KDn, 1, 0, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(b, KMode, 1, 1, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(b, KMode, 1, 2, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(b, KMode, 1, 3, 1, tm(24, 2, 28, 13, 45, 10)));
    tbl.push_back(v(b, KCan, 0, 0, 0, b));
    // Session C: wrap at every field boundary.
    tbl.push_back(v(c, KMode, 1, 0, 1, c));
    tbl.push_back(v(c, KUp, 1, 0, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KMode, 1, 1, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KUp, 1, 1, 1, tm(0, 1, 31, 23, 59, 59)));
    tbl.push_back(v(c, KDn, 1, 1, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KMode, 1, 2, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KUp, 1, 2, 1, tm(0, 12, 1, 23, 59, 59)));
    tbl.push_back(v(c, KDn, 1, 2, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KUp | KDn, 1, 2, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KMode, 1, 3, 1, tm(0, 12, 31, 23, 59, 59)));
    tbl.push_back(v(c, KUp, 1, 3, 1, tm(0, 12, 31, 0, 59, 59)));
    tbl.push_back(v(c, KMode, 1, 4, 1, tm(0, 12, 31, 0, 59, 59)));
    tbl.push_back(v(c, KUp, 1, 4, 1, tm(0, 12, 31, 0, 0, 59)));
    tbl.push_back(v(c, KMode, 1, 5, 1, tm(0, 12, 31, 0, 0, 59)));
    tbl.push_back(v(c, KUp, 1, 5, 1, tm(0, 12, 31, 0, 0, 0)));
    tbl.push_back(v(c, KDn, 1, 5, 1, tm(0, 12, 31, 0, 0, 59)));
    tbl.push_back(v(c, KCan, 0, 0, 0, c));

    rst = 1'b1;
    bus.sw_in = 4'd0;
    set_live(b);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("reset");

    // Entry latency, shadow capture and blink phase.
    bus.sw_in = KMode;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 10) bus.sw_in = 4'd0;
      if (k == 6) chk("entry early", 64'(bus.edit_active), 64'(1'b0));
      if (k == 7) begin
        chk("entry active", 64'(bus.edit_active), 64'(1'b1));
        chk("entry field", 64'(bus.edit_field), 64'(3'd0));
        chk("entry shadow", 64'(dut.shadow_q), 64'(b));
      end
      if (k == 14) chk("blink low", 64'(bus.blink), 64'(1'b0));
      if (k == 15) chk("blink high", 64'(bus.blink), 64'(1'b1));
    end
    repeat (8) tick();
    press(KCan, 6);
    chk("entry cancel", 64'(bus.edit_active), 64'(1'b0));
    chk("cancel blink", 64'(bus.blink), 64'(1'b0));

    foreach (tbl[i]) begin
      set_live(tbl[i].live);
      press(tbl[i].keys, 6);
      chk($sformatf("v%0d active", i), 64'(bus.edit_active), 64'(tbl[i].act));
      chk($sformatf("v%0d field", i), 64'(bus.edit_field), 64'(tbl[i].fld));
      if (tbl[i].chk_sh) chk($sformatf("v%0d shadow", i), 64'(dut.shadow_q), 64'(tbl[i].sh));
      if (i == 11) commit_seq(tm(24, 2, 28, 13, 45, 10));
    end
    chk("bin_time held", 64'(bus.bin_time), 64'(tm(24, 2, 28, 13, 45, 10)));

    // Glitch rejection, auto-repeat timing on minute, then idle timeout.
    set_live(tm(24, 2, 29, 13, 58, 10));
    repeat (5) press(KMode, 6);
    chk("rep field", 64'(bus.edit_field), 64'(3'd4));
    bus.sw_in = KUp;
    repeat (3) tick();
    bus.sw_in = 4'd0;
    repeat (10) tick();
    chk("glitch", 64'(dut.shadow_q.minute), 64'(8'd58));
    bus.sw_in = KUp;
    for (int k = 1; k <= 242; k++) begin
      tick();
      if (k == 40) bus.sw_in = 4'd0;
      mexp = -1;
      case (k)
        6: mexp = 58;
        7, 26: mexp = 59;
        27, 31: mexp = 0;
        32: mexp = 1;
        37: mexp = 2;
        42, 60: mexp = 3;
        default: ;
      endcase
      if (mexp >= 0) chk($sformatf("repeat +%0d", k), 64'(dut.shadow_q.minute), 64'(mexp));
      if (k == 241) chk("timeout early", 64'(bus.edit_active), 64'(1'b1));
      if (k == 242) chk("timeout idle", 64'(bus.edit_active), 64'(1'b0));
    end
    chk("timeout no load", 64'(set_cnt), 64'(1));

    // Reset in the middle of an edit.
    set_live(b);
    press(KMode, 6);
    press(KMode, 6);
    press(KUp, 6);
    chk("pre-rst shadow", 64'(dut.shadow_q), 64'(tm(24, 3, 29, 13, 45, 10)));
    rst = 1'b1;
    tick();
    chk_reset_outputs("mid rst");
    chk("mid rst shadow", 64'(dut.shadow_q), 64'(ResetTime));
    rst = 1'b0;
    tick();
    t = tm(23, 7, 4, 9, 8, 7);
    set_live(t);
    press(KMode, 6);
    chk("re-entry shadow", 64'(dut.shadow_q), 64'(t));
    press(KCan, 6);
    chk("final load count", 64'(set_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
